// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and the per-cycle operation type used by the counter.
package gray_pkg;

    localparam int GRAY_MAX_W = 32;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_STEP = 2'd2
    } gray_op_e;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down, done in log2 doubling passes.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b = g;
        for (int unsigned s = 1; s < GRAY_MAX_W; s = s << 1) begin
            b = b ^ (b >> s);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_counter_bin_to_gray.sv
// Combinational binary-to-Gray encoder.
module bin_to_gray #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_bin,
    output logic [N-1:0] o_gray
);

    assign o_gray = i_bin ^ (i_bin >> 1);

endmodule

// File: rtl/gray_counter.sv
// Registered up/down counter emitting both binary and Gray code, with wrap pulse.
module gray_counter
    import gray_pkg::*;
#(
    parameter int           N         = 4,
    parameter logic [N-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         up,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] bin_out,
    output logic [N-1:0] gray_out,
    output logic         wrap
);

    localparam logic [GRAY_MAX_W-1:0] RESET_GRAY_W =
        bin2gray({{(GRAY_MAX_W-N){1'b0}}, RESET_VAL});
    localparam logic [N-1:0] RESET_GRAY = RESET_GRAY_W[N-1:0];
    localparam logic [N-1:0] ONE        = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] r_bin;
    logic [N-1:0] r_gray;
    logic         r_wrap;

    gray_op_e     w_op;
    logic [N-1:0] w_bin_step;
    logic         w_wrap_step;
    logic [N-1:0] w_bin_next;
    logic [N-1:0] w_gray_next;
    logic         w_wrap_next;

    assign w_bin_step  = up ? (r_bin + ONE) : (r_bin - ONE);
    assign w_wrap_step = up ? (&r_bin) : ~(|r_bin);

    always_comb begin
        w_op        = OP_HOLD;
        w_bin_next  = r_bin;
        w_wrap_next = 1'b0;
        if (load) begin
            w_op = OP_LOAD;
        end else if (en) begin
            w_op = OP_STEP;
        end
        case (w_op)
            OP_LOAD: w_bin_next = load_val;
            OP_STEP: begin
                w_bin_next  = w_bin_step;
                w_wrap_next = w_wrap_step;
            end
            default: w_bin_next = r_bin;
        endcase
    end

    // Gray is encoded from the next binary value so both registers update on the same edge.
    bin_to_gray #(.N(N)) u_bin_to_gray (
        .i_bin  (w_bin_next),
        .o_gray (w_gray_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bin  <= RESET_VAL;
            r_gray <= RESET_GRAY;
            r_wrap <= 1'b0;
        end else begin
            r_bin  <= w_bin_next;
            r_gray <= w_gray_next;
            r_wrap <= w_wrap_next;
        end
    end

    assign bin_out  = r_bin;
    assign gray_out = r_gray;
    assign wrap     = r_wrap;

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter (N=4): directed steps plus a random run.
module tb_gray_counter;
    import gray_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n, en, up, load;
    logic [3:0] load_val;
    logic [3:0] bin_out, gray_out;
    logic       wrap;

    typedef struct packed {
        logic [3:0] bin;
        logic [3:0] gray;
        logic       wrap;
    } exp_t;

    exp_t       q[$];
    logic [3:0] m_bin;
    int         n_checks = 0;
    int         n_pass   = 0;

    gray_counter #(.N(4), .RESET_VAL(4'd0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .bin_out  (bin_out),
        .gray_out (gray_out),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic expect_out(input string tag, input logic [3:0] b, input logic [3:0] g,
                              input logic w);
        check({tag, ".bin"},  {28'b0, bin_out},  {28'b0, b});
        check({tag, ".gray"}, {28'b0, gray_out}, {28'b0, g});
        check({tag, ".wrap"}, {31'b0, wrap},     {31'b0, w});
    endtask

    // Drive one cycle, push the model's expectation, then pop and compare after the edge.
    task automatic step(input logic rn, input logic e, input logic u, input logic l,
                        input logic [3:0] lv);
        exp_t        x;
        logic [3:0]  prev_gray;
        logic        counted;
        logic [31:0] rec;
        rst_n = rn; en = e; up = u; load = l; load_val = lv;
        counted   = rn && !l && e;
        prev_gray = gray_out;
        x.wrap = 1'b0;
        if (!rn) begin
            m_bin = 4'd0;
        end else if (l) begin
            m_bin = lv;
        end else if (e) begin
            if (u) begin
                x.wrap = (m_bin == 4'd15);
                m_bin  = m_bin + 4'd1;
            end else begin
                x.wrap = (m_bin == 4'd0);
                m_bin  = m_bin - 4'd1;
            end
        end
        x.bin  = m_bin;
        x.gray = m_bin ^ (m_bin >> 1);
        q.push_back(x);
        @(posedge clk);
        #1;
        x = q.pop_front();
        check("sb.bin",  {28'b0, bin_out},  {28'b0, x.bin});
        check("sb.gray", {28'b0, gray_out}, {28'b0, x.gray});
        check("sb.wrap", {31'b0, wrap},     {31'b0, x.wrap});
        rec = gray2bin({28'b0, gray_out});
        check("inv.g2b", {28'b0, rec[3:0]}, {28'b0, bin_out});
        if (counted)
            check("inv.hamming", $countones(prev_gray ^ gray_out), 32'd1);
    endtask

    logic [3:0] gt [17];

    initial begin
        gt = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
               4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000,
               4'b0000};
        m_bin = 4'd0;
        rst_n = 1'b0; en = 1'b1; up = 1'b1; load = 1'b0; load_val = 4'd0;
        #1;

        // Reset with en high
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        expect_out("reset", 4'd0, 4'b0000, 1'b0);

        // Count up through a full wrap
        for (int unsigned i = 0; i < 16; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
            check("up.gray", {28'b0, gray_out}, {28'b0, gt[i+1]});
            check("up.wrap", {31'b0, wrap}, {31'b0, (i == 15)});
        end

        // Count down across zero
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        expect_out("down.wrap", 4'd15, 4'b1000, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        expect_out("down.next", 4'd14, 4'b1001, 1'b0);

        // Load beats en
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'd10);
        expect_out("load", 4'd10, 4'b1111, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        expect_out("load.next", 4'd11, 4'b1110, 1'b0);

        // Hold, then toggle direction
        step(1'b1, 1'b0, 1'b1, 1'b1, 4'd5);
        expect_out("hold.load", 4'd5, 4'b0111, 1'b0);
        for (int unsigned i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
            expect_out("hold", 4'd5, 4'b0111, 1'b0);
        end
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        expect_out("dir.up", 4'd6, 4'b0101, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        expect_out("dir.down", 4'd5, 4'b0111, 1'b0);

        // Reset at 15 while counting up: no wrap pulse
        step(1'b1, 1'b0, 1'b1, 1'b1, 4'd15);
        expect_out("mid.load", 4'd15, 4'b1000, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        expect_out("mid.reset", 4'd0, 4'b0000, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        expect_out("mid.after", 4'd0, 4'b0000, 1'b0);

        // Random run
        for (int unsigned i = 0; i < 10000; i++) begin
            step(($urandom_range(63) != 0), 1'($urandom_range(3) != 0), 1'($urandom_range(1)),
                 ($urandom_range(7) == 0), 4'($urandom_range(15)));
        end

        check("sb.empty", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
